// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths, zero constants and the writeback request type for
//            the register-file write-side arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wbarb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wbarb_fifo
// Purpose  : Small synchronous FIFO holding long-latency writeback results.
//            Every entry carries a valid bit that can be cleared in place by
//            the squash port, so a squashed entry still drains in order but
//            produces no register write.
// Ports    : clk, rst                          clock / sync active-high reset
//            push, push_addr, push_data        enqueue at tail (caller keeps
//                                              push low when full)
//            pop                               dequeue head (caller keeps pop
//                                              low when empty)
//            squash_en, squash_addr            clear valid of matching entries
//            head_valid, head_addr, head_data  current head entry
//            count                             number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module wbarb_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [ADDR_W-1:0] squash_addr,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);
    import wb_pkg::*;

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;

    // Payload storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_addr[r_tail] <= push_addr;
            r_data[r_tail] <= push_data;
        end
    end

    // An entry written this cycle is always valid: the incoming result is
    // younger than any write squashing the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (r_tail == c_ptr_w'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (squash_en && (r_addr[i] == squash_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            if (pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_valid = r_valid[r_head];
    assign head_addr  = r_addr[r_head];
    assign head_data  = r_data[r_head];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Write-side master for the register file's single write port.
//            In-order pipeline writeback has priority and no backpressure;
//            long-latency results (load/div) arrive over valid/ready and wait
//            in a small FIFO. The pipeline is stalled for one cycle whenever
//            it has starved a non-empty FIFO for STARVE_LIMIT cycles.
// Ports    : clk, rst                                clock / sync reset
//            pipe_we_i, pipe_waddr_i, pipe_wdata_i   pipeline writeback
//            pipe_stall_o                            pipeline must not write
//            ll_valid_i, ll_ready_o,
//            ll_waddr_i, ll_wdata_i                  long-latency results
//            we_o, waddr_o, wdata_o                  registered regfile write
//            fifo_count_o                            FIFO occupancy
// Config   : WBARB_WAW_SQUASH_EN - when defined, an accepted pipeline write
//            to X invalidates every queued long-latency entry for X.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we_i,
    input  logic [ADDR_W-1:0]      pipe_waddr_i,
    input  logic [DATA_W-1:0]      pipe_wdata_i,
    output logic                   pipe_stall_o,
    input  logic                   ll_valid_i,
    output logic                   ll_ready_o,
    input  logic [ADDR_W-1:0]      ll_waddr_i,
    input  logic [DATA_W-1:0]      ll_wdata_i,
    output logic                   we_o,
    output logic [ADDR_W-1:0]      waddr_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic [$clog2(DEPTH):0] fifo_count_o
);
    import wb_pkg::*;

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W-1:0]  c_zero_reg  = ADDR_W'(ZERO_REG);
    localparam logic [DATA_W-1:0]  c_zero_word = DATA_W'(ZERO_WORD);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_stv_w-1:0] c_limit     = c_stv_w'(STARVE_LIMIT);

    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_stall;
    logic [c_stv_w-1:0]  r_starve;

    logic [c_cnt_w-1:0]  w_count;
    logic                w_head_valid;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_fifo_ne;
    logic                w_ll_ready;
    logic                w_push;
    logic                w_pipe_req;
    logic                w_pop;
    logic                w_squash_en;
    logic [ADDR_W-1:0]   w_squash_addr;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [c_stv_w-1:0]  w_starve_nxt;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even in a cycle where its head is popped.
    assign w_ll_ready = (w_count < c_depth) && !rst;
    assign w_fifo_ne  = (w_count != '0);

    // Results targeting r0 are handshaken but never stored.
    assign w_push     = ll_valid_i && w_ll_ready && (ll_waddr_i != c_zero_reg);
    assign w_pipe_req = pipe_we_i && (pipe_waddr_i != c_zero_reg) && !r_stall;

`ifdef WBARB_WAW_SQUASH_EN
    assign w_squash_en   = w_pipe_req;
    assign w_squash_addr = pipe_waddr_i;
`else
    assign w_squash_en   = 1'b0;
    assign w_squash_addr = c_zero_reg;
`endif

    wbarb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (c_cnt_w)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_addr   (ll_waddr_i),
        .push_data   (ll_wdata_i),
        .pop         (w_pop),
        .squash_en   (w_squash_en),
        .squash_addr (w_squash_addr),
        .head_valid  (w_head_valid),
        .head_addr   (w_head_addr),
        .head_data   (w_head_data),
        .count       (w_count)
    );

    // Write selection and starvation bookkeeping. A squashed head is
    // discarded silently, even while the pipeline owns the write port, so
    // dead entries never hold up live ones. Without squashing the head
    // valid bit is always set and those paths are inert.
    always_comb begin
        w_pop        = 1'b0;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_starve_nxt = r_starve;

        if (w_pipe_req) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = pipe_waddr_i;
            w_wdata_nxt = pipe_wdata_i;
            w_pop       = w_fifo_ne && !w_head_valid;
        end else if (w_fifo_ne) begin
            w_pop = 1'b1;
            if (w_head_valid) begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = w_head_addr;
                w_wdata_nxt = w_head_data;
            end
        end

        // The counter cannot pass the limit: the stall cycle that follows
        // reaching it always pops the head and clears the count.
        if (w_pop || !w_fifo_ne) begin
            w_starve_nxt = '0;
        end else if (w_pipe_req) begin
            w_starve_nxt = r_starve + c_stv_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_waddr  <= c_zero_reg;
            r_wdata  <= c_zero_word;
            r_stall  <= 1'b0;
            r_starve <= '0;
        end else begin
            r_we     <= w_we_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == c_limit);
        end
    end

    assign pipe_stall_o = r_stall;
    assign ll_ready_o   = w_ll_ready;
    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign wdata_o      = r_wdata;
    assign fifo_count_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed scoreboard bench for regfile_wb_arbiter. Stimulus pushes
//            the register writes it expects, in order; a negedge monitor pops
//            and compares every write the DUT presents. Point checks cover
//            reset, latency, occupancy, readiness and the starvation stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic              clk;
    logic              rst;
    logic              pipe_we_i;
    logic [ADDR_W-1:0] pipe_waddr_i;
    logic [DATA_W-1:0] pipe_wdata_i;
    logic              pipe_stall_o;
    logic              ll_valid_i;
    logic              ll_ready_o;
    logic [ADDR_W-1:0] ll_waddr_i;
    logic [DATA_W-1:0] ll_wdata_i;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [2:0]        fifo_count_o;

    int      n_checks = 0;
    int      n_pass   = 0;
    wb_req_t exp_q[$];

    regfile_wb_arbiter #(
        .ADDR_W       (5),
        .DATA_W       (32),
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we_i    (pipe_we_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_wdata_i (pipe_wdata_i),
        .pipe_stall_o (pipe_stall_o),
        .ll_valid_i   (ll_valid_i),
        .ll_ready_o   (ll_ready_o),
        .ll_waddr_i   (ll_waddr_i),
        .ll_wdata_i   (ll_wdata_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .fifo_count_o (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_req_t e;
        e.we    = 1'b1;
        e.waddr = a;
        e.wdata = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pipe_we_i    = we;
        pipe_waddr_i = a;
        pipe_wdata_i = d;
    endtask

    task automatic ll(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ll_valid_i = v;
        ll_waddr_i = a;
        ll_wdata_i = d;
    endtask

    // Monitor: every presented write must match the oldest expectation.
    always @(negedge clk) begin
        wb_req_t e;
        if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got r%0d=0x%08h, required no write", waddr_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(waddr_o), 32'(e.waddr));
                chk("wr_data", wdata_o, e.wdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b1, 5'd1, 32'h1234);

        // Reset held two cycles with a long-latency result offered.
        step();
        step();
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_ready", 32'(ll_ready_o), 32'd0);
        chk("rst_stall", 32'(pipe_stall_o), 32'd0);
        rst = 1'b0;
        ll(1'b0, 5'd0, 32'h0);
        #1;
        chk("ready_after_rst", 32'(ll_ready_o), 32'd1);

        // Pipe-only: one-cycle latency; r0 writes are dropped.
        pipe(1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        chk("pipe_we", 32'(we_o), 32'd1);
        chk("pipe_waddr", 32'(waddr_o), 32'd5);
        chk("pipe_wdata", wdata_o, 32'hDEADBEEF);
        pipe(1'b1, 5'd0, 32'hCAFE0000);
        step();
        chk("r0_we", 32'(we_o), 32'd0);
        chk("r0_hold_addr", 32'(waddr_o), 32'd5);
        chk("r0_hold_data", wdata_o, 32'hDEADBEEF);
        pipe(1'b0, 5'd0, 32'h0);

        // Queue drain: two results, pipe idle.
        ll(1'b1, 5'd3, 32'h11);
        expect_wr(5'd3, 32'h11);
        step();
        chk("ll_no_bypass", 32'(we_o), 32'd0);
        ll(1'b1, 5'd4, 32'h22);
        expect_wr(5'd4, 32'h22);
        step();
        chk("drain1_addr", 32'(waddr_o), 32'd3);
        ll(1'b0, 5'd0, 32'h0);
        step();
        chk("drain2_addr", 32'(waddr_o), 32'd4);
        chk("drain2_data", wdata_o, 32'h22);
        step();
        chk("drain_idle_we", 32'(we_o), 32'd0);
        chk("drain_count", 32'(fifo_count_o), 32'd0);

        // Full FIFO under continuous pipe writes, then a forced drain.
        for (int k = 0; k < 10; k++) begin
            pipe(1'b1, 5'(10 + k), 32'h1000 + k);
            if (k < 4) ll(1'b1, 5'(20 + k), 32'h200 + k);
            else       ll(1'b1, 5'd24, 32'h224);
            if (k == 8) chk("stall_not_yet", 32'(pipe_stall_o), 32'd0);
            if (k == 9) chk("stall_asserted", 32'(pipe_stall_o), 32'd1);
            if (k <= 8) expect_wr(5'(10 + k), 32'h1000 + k);
            else        expect_wr(5'd20, 32'h200);
            step();
            if (k == 3) begin
                chk("full_count", 32'(fifo_count_o), 32'd4);
                chk("full_ready", 32'(ll_ready_o), 32'd0);
            end
            if (k == 8) chk("full_held_count", 32'(fifo_count_o), 32'd4);
        end
        chk("stall_one_cycle", 32'(pipe_stall_o), 32'd0);
        chk("stall_pop_addr", 32'(waddr_o), 32'd20);
        chk("stall_pop_count", 32'(fifo_count_o), 32'd3);
        pipe(1'b0, 5'd0, 32'h0);
        expect_wr(5'd21, 32'h201);
        step();
        ll(1'b0, 5'd0, 32'h0);
        chk("refill_count", 32'(fifo_count_o), 32'd3);
        expect_wr(5'd22, 32'h202);
        expect_wr(5'd23, 32'h203);
        expect_wr(5'd24, 32'h224);
        step();
        step();
        step();
        chk("full_drain_count", 32'(fifo_count_o), 32'd0);
        step();
        chk("full_drain_idle", 32'(we_o), 32'd0);

        // Same-cycle pipe and long-latency with the FIFO empty.
        pipe(1'b1, 5'd7, 32'h77);
        ll(1'b1, 5'd9, 32'h99);
        expect_wr(5'd7, 32'h77);
        expect_wr(5'd9, 32'h99);
        step();
        chk("prio_first", 32'(waddr_o), 32'd7);
        chk("prio_count", 32'(fifo_count_o), 32'd1);
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b0, 5'd0, 32'h0);
        step();
        chk("prio_second", 32'(waddr_o), 32'd9);

        // Long-latency result for r0 is accepted but not stored.
        ll(1'b1, 5'd0, 32'h55);
        step();
        ll(1'b0, 5'd0, 32'h0);
        chk("ll_r0_count", 32'(fifo_count_o), 32'd0);
        step();
        chk("ll_r0_no_write", 32'(we_o), 32'd0);

        // Write-after-write on r6: queued 0xAA, then pipe 0xBB.
        pipe(1'b1, 5'd8, 32'h88);
        ll(1'b1, 5'd6, 32'hAA);
        expect_wr(5'd8, 32'h88);
        step();
        pipe(1'b1, 5'd6, 32'hBB);
        ll(1'b0, 5'd0, 32'h0);
        expect_wr(5'd6, 32'hBB);
        step();
        pipe(1'b0, 5'd0, 32'h0);
`ifndef WBARB_WAW_SQUASH_EN
        expect_wr(5'd6, 32'hAA);
`endif
        step();
        chk("waw_count", 32'(fifo_count_o), 32'd0);
`ifdef WBARB_WAW_SQUASH_EN
        chk("waw_squashed", 32'(we_o), 32'd0);
`else
        chk("waw_drained", wdata_o, 32'hAA);
`endif
        step();
        chk("waw_idle", 32'(we_o), 32'd0);

        // Reset mid-operation discards a queued entry.
        pipe(1'b1, 5'd11, 32'h111);
        ll(1'b1, 5'd12, 32'h122);
        expect_wr(5'd11, 32'h111);
        step();
        chk("midrst_pre_count", 32'(fifo_count_o), 32'd1);
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b0, 5'd0, 32'h0);
        step();
        chk("midrst_count", 32'(fifo_count_o), 32'd0);
        chk("midrst_we", 32'(we_o), 32'd0);
        chk("midrst_ready", 32'(ll_ready_o), 32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("midrst_after_count", 32'(fifo_count_o), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
